multicycle_memory: RTL

Unified instruction/data memory for the multicycle core, with a configurable access latency and a ready handshake. It sits directly downstream of the control unit and serves every fetch (IF1/IF2) and data access (MEM). The control unit holds its strobes until `ready` pulses, and only then leaves the current state. Read data goes to the instruction register and the memory data register through `dout`.

---
 rtl/multicycle_memory.sv | 127 ++++++++++++
 1 files changed

// File: rtl/multicycle_memory.sv
// Unified instruction/data memory for the multicycle core: latched request,
// LATENCY-cycle access, one-cycle ready/err completion pulse.
module multicycle_memory #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      din_q;
    logic             rd_q;
    logic             wr_q;

    logic             load_c;
    logic             fire_c;
    logic             illegal_c;
    logic [IDX_W-1:0] idx_c;

    logic [31:0]      mem [DEPTH];

    assign idx_c     = addr_q[IDX_W+1:2];
    assign illegal_c = (rd_q & wr_q)
                     | (addr_q[1:0] != 2'b00)
                     | (32'(addr_q[31:2]) >= 32'(DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; DONE hands off straight to WAIT when a strobe is still up,
    // which gives the LATENCY+1 request spacing.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        fire_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read | mem_write) begin
                    load_c  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    fire_c  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (mem_read | mem_write) begin
                    load_c  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latch, latency counter and registered completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            addr_q <= '0;
            din_q  <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
            dout   <= '0;
        end else begin
            ready <= fire_c;
            err   <= fire_c & illegal_c;
            busy  <= (state_q == S_WAIT);
            if (load_c) begin
                addr_q <= addr;
                din_q  <= din;
                rd_q   <= mem_read;
                wr_q   <= mem_write;
                cnt_q  <= CNT_W'(LATENCY - 1);
            end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (fire_c && rd_q && !wr_q) begin
                dout <= illegal_c ? 32'h0 : mem[idx_c];
            end
        end
    end

    // Array write port; contents survive reset, and a reset edge never writes.
    always_ff @(posedge clk) begin
        if (!reset && fire_c && wr_q && !rd_q && !illegal_c) begin
            mem[idx_c] <= din_q;
        end
    end

endmodule
